// File: rtl/test_card_pkg.sv
// Shared types and constants for the test-card generator: pattern modes and
// the colour-bar palette as 3-bit {R,G,B} masks.
package test_card_pkg;

  typedef enum logic [1:0] {
    MODE_GRAD  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } mode_t;

  localparam int BARS = 8;

  localparam logic [2:0] RGB_WHITE   = 3'b111;
  localparam logic [2:0] RGB_YELLOW  = 3'b110;
  localparam logic [2:0] RGB_CYAN    = 3'b011;
  localparam logic [2:0] RGB_GREEN   = 3'b010;
  localparam logic [2:0] RGB_MAGENTA = 3'b101;
  localparam logic [2:0] RGB_RED     = 3'b100;
  localparam logic [2:0] RGB_BLUE    = 3'b001;
  localparam logic [2:0] RGB_BLACK   = 3'b000;

  // Bar 0 sits in the least significant slot.
  localparam logic [BARS*3-1:0] BAR_MASKS = {
    RGB_BLACK, RGB_BLUE, RGB_RED, RGB_MAGENTA,
    RGB_GREEN, RGB_CYAN, RGB_YELLOW, RGB_WHITE
  };

  function automatic logic [2:0] bar_mask(input logic [2:0] k);
    return BAR_MASKS[int'(k)*3 +: 3];
  endfunction

endpackage

// File: rtl/test_card_bar_index.sv
// Colour-bar index: counts the elaboration-time bar boundaries at or left of sx.
// Anything at or beyond H_RES lands in the last bar.
module test_card_bar_index
  import test_card_pkg::*;
#(
  parameter int CORDW = 16,
  parameter int H_RES = 640
) (
  input  logic [CORDW-1:0] i_sx,
  output logic [2:0]       o_k
);

  always_comb begin
    o_k = 3'd0;
    for (int i = 1; i < BARS; i++) begin
      if (i_sx >= CORDW'((i * H_RES) / BARS)) o_k = o_k + 3'd1;
    end
  end

endmodule

// File: rtl/test_card_gen.sv
// Pipelined test-card generator (gradient, bars, checker, solid), 2-cycle latency.
// Define TEST_CARD_SCROLL_EN to enable the per-frame scroll offset.
module test_card_gen
  import test_card_pkg::*;
#(
  parameter int               CORDW       = 16,
  parameter int               CHANW       = 8,
  parameter int               H_RES       = 640,
  parameter int               XSHIFT      = 2,
  parameter int               CHECK_SHIFT = 5,
  parameter logic [CHANW-1:0] STEP        = 1,
  parameter logic [CHANW-1:0] BASE_R      = 'h00,
  parameter logic [CHANW-1:0] BASE_G      = 'h10,
  parameter logic [CHANW-1:0] BASE_B      = 'h4C
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] i_sx,
  input  logic [CORDW-1:0] i_sy,
  input  logic             i_de,
  input  logic             i_frame,
  input  logic [1:0]       i_mode,
  input  logic             i_pause,
  output logic [CHANW-1:0] o_red,
  output logic [CHANW-1:0] o_green,
  output logic [CHANW-1:0] o_blue,
  output logic             o_de,
  output logic [1:0]       o_mode
);

  mode_t            r_mode;
  logic [CHANW-1:0] w_offset;
  logic [CHANW-1:0] w_sx_t;
  logic [CHANW-1:0] w_sy_t;
  logic [2:0]       w_k;
  logic             w_unused_sy;

  assign w_sx_t      = i_sx[CHANW-1:0];
  assign w_sy_t      = i_sy[CHANW-1:0];
  assign w_unused_sy = ^i_sy;

  always_ff @(posedge clk_pix) begin
    if (rst_pix)      r_mode <= MODE_GRAD;
    else if (i_frame) r_mode <= mode_t'(i_mode);
  end

  assign o_mode = r_mode;

`ifdef TEST_CARD_SCROLL_EN
  logic [CHANW-1:0] r_offset;

  always_ff @(posedge clk_pix) begin
    if (rst_pix)                  r_offset <= '0;
    else if (i_frame && !i_pause) r_offset <= r_offset + STEP;
  end

  assign w_offset = r_offset;
`else
  logic w_unused_cfg;

  assign w_offset     = '0;
  assign w_unused_cfg = ^{i_pause, STEP};
`endif

  test_card_bar_index #(
    .CORDW (CORDW),
    .H_RES (H_RES)
  ) u_bar_index (
    .i_sx (i_sx),
    .o_k  (w_k)
  );

  // Stage 1: per-mode intermediates, captured with the mode/offset in force now
  logic [CHANW-1:0] r_gr_p1, r_gg_p1, r_gb_p1, r_off_p1;
  logic [2:0]       r_k_p1;
  logic             r_chk_p1;
  mode_t            r_mode_p1;
  logic             r_vld_p1;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_gr_p1   <= '0;
      r_gg_p1   <= '0;
      r_gb_p1   <= '0;
      r_off_p1  <= '0;
      r_k_p1    <= '0;
      r_chk_p1  <= 1'b0;
      r_mode_p1 <= MODE_GRAD;
      r_vld_p1  <= 1'b0;
    end else begin
      r_gr_p1   <= BASE_R + w_sy_t + (w_sx_t >> XSHIFT) + w_offset;
      r_gg_p1   <= BASE_G + w_sy_t;
      r_gb_p1   <= BASE_B + w_sy_t + w_offset;
      r_off_p1  <= w_offset;
      r_k_p1    <= w_k;
      r_chk_p1  <= i_sx[CHECK_SHIFT] ^ i_sy[CHECK_SHIFT] ^ w_offset[0];
      r_mode_p1 <= r_mode;
      r_vld_p1  <= i_de;
    end
  end

  function automatic logic [CHANW-1:0] expand(input logic b);
    return {CHANW{b}};
  endfunction

  logic [2:0]       w_mask;
  logic [CHANW-1:0] w_r, w_g, w_b;

  assign w_mask = bar_mask(r_k_p1);

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (r_vld_p1) begin
      unique case (r_mode_p1)
        MODE_GRAD: begin
          w_r = r_gr_p1;
          w_g = r_gg_p1;
          w_b = r_gb_p1;
        end
        MODE_BARS: begin
          w_r = expand(w_mask[2]);
          w_g = expand(w_mask[1]);
          w_b = expand(w_mask[0]);
        end
        MODE_CHECK: begin
          w_r = expand(r_chk_p1);
          w_g = expand(r_chk_p1);
          w_b = expand(r_chk_p1);
        end
        MODE_SOLID: begin
          w_r = r_off_p1;
          w_g = r_off_p1;
          w_b = r_off_p1;
        end
      endcase
    end
  end

  // Stage 2: colour mux output, blanked outside DE
  logic [CHANW-1:0] r_red_p2, r_green_p2, r_blue_p2;
  logic             r_vld_p2;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_red_p2   <= '0;
      r_green_p2 <= '0;
      r_blue_p2  <= '0;
      r_vld_p2   <= 1'b0;
    end else begin
      r_red_p2   <= w_r;
      r_green_p2 <= w_g;
      r_blue_p2  <= w_b;
      r_vld_p2   <= r_vld_p1;
    end
  end

  assign o_red   = r_red_p2;
  assign o_green = r_green_p2;
  assign o_blue  = r_blue_p2;
  assign o_de    = r_vld_p2;

endmodule

// File: tb/tb_test_card_gen.sv
// Directed and random-stream bench for test_card_gen (default parameters).
// Honours TEST_CARD_SCROLL_EN the same way as the design.
module tb_test_card_gen;

`ifdef TEST_CARD_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif
  localparam logic [7:0] SOLID3 = SCROLL ? 8'h03 : 8'h00;

  logic        clk_pix = 1'b0;
  logic        rst_pix;
  logic [15:0] i_sx, i_sy;
  logic        i_de, i_frame, i_pause;
  logic [1:0]  i_mode;
  logic [7:0]  o_red, o_green, o_blue;
  logic        o_de;
  logic [1:0]  o_mode;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [1:0]  m_mode;
  logic [7:0]  m_off;
  logic [24:0] q[$];

  localparam logic [23:0] BAR_TAB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  always #5 clk_pix = ~clk_pix;

  test_card_gen dut (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .i_sx    (i_sx),
    .i_sy    (i_sy),
    .i_de    (i_de),
    .i_frame (i_frame),
    .i_mode  (i_mode),
    .i_pause (i_pause),
    .o_red   (o_red),
    .o_green (o_green),
    .o_blue  (o_blue),
    .o_de    (o_de),
    .o_mode  (o_mode)
  );

  function automatic logic [24:0] model(input int sx, input int sy, input logic de,
                                        input logic [1:0] md, input logic [7:0] off);
    logic [7:0] x8, y8, r, g, b;
    int k;
    x8 = sx[7:0];
    y8 = sy[7:0];
    r = 8'h00;
    g = 8'h00;
    b = 8'h00;
    if (!de) return 25'd0;
    case (md)
      2'd0: begin
        r = 8'h00 + y8 + (x8 >> 2) + off;
        g = 8'h10 + y8;
        b = 8'h4C + y8 + off;
      end
      2'd1: begin
        k = (sx >= 640) ? 7 : sx / 80;
        {r, g, b} = BAR_TAB[k];
      end
      2'd2: begin
        r = {8{sx[5] ^ sy[5] ^ off[0]}};
        g = r;
        b = r;
      end
      default: begin
        r = off;
        g = off;
        b = off;
      end
    endcase
    return {1'b1, r, g, b};
  endfunction

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int sx, input int sy, input logic de);
    i_sx = 16'(sx);
    i_sy = 16'(sy);
    i_de = de;
  endtask

  // Present one pixel, wait out the 2-cycle latency, compare {de,R,G,B}.
  task automatic show(input string tag, input int sx, input int sy, input logic [23:0] rgb);
    pix(sx, sy, 1'b1);
    tick();
    tick();
    check(tag, {7'd0, o_de, o_red, o_green, o_blue}, {8'd1, rgb});
  endtask

  task automatic frame(input logic [1:0] md, input logic p);
    i_mode  = md;
    i_pause = p;
    i_frame = 1'b1;
    tick();
    i_frame = 1'b0;
    m_mode  = md;
    if (SCROLL && !p) m_off = m_off + 8'd1;
  endtask

  initial begin
    rst_pix = 1'b1;
    i_frame = 1'b0;
    i_mode  = 2'd0;
    i_pause = 1'b0;
    m_mode  = 2'd0;
    m_off   = 8'd0;
    pix(0, 0, 1'b0);
    repeat (3) tick();
    check("reset_outputs", {7'd0, o_de, o_red, o_green, o_blue}, 32'd0);
    check("reset_mode", {30'd0, o_mode}, 32'd0);

    pix(0, 0, 1'b1);
    rst_pix = 1'b0;
    check("de_after_release_0", {31'd0, o_de}, 32'd0);
    tick();
    check("de_after_release_1", {31'd0, o_de}, 32'd0);
    tick();
    check("grad_origin", {7'd0, o_de, o_red, o_green, o_blue}, {8'd1, 24'h00104C});

    show("grad_40_100", 40, 100, 24'h6E74B0);
    show("grad_40_200", 40, 200, 24'hD2D814);

    i_mode = 2'd1;
    tick();
    check("mode_ignored_without_frame", {30'd0, o_mode}, 32'd0);
    frame(2'd1, 1'b0);
    check("mode_after_frame", {30'd0, o_mode}, 32'd1);
    show("bars_0", 0, 10, 24'hFFFFFF);
    show("bars_79", 79, 10, 24'hFFFFFF);
    show("bars_80", 80, 10, 24'hFFFF00);
    show("bars_559", 559, 10, 24'h0000FF);
    show("bars_639", 639, 10, 24'h000000);
    show("bars_700", 700, 10, 24'h000000);

    frame(2'd2, 1'b0);
    show("chk_31_0", 31, 0, {24{m_off[0]}});
    show("chk_32_0", 32, 0, {24{~m_off[0]}});
    show("chk_32_32", 32, 32, {24{m_off[0]}});
    frame(2'd2, 1'b0);
    show("chk_31_0_next", 31, 0, {24{m_off[0]}});

    pix(40, 100, 1'b0);
    tick();
    tick();
    check("de_low_black", {7'd0, o_de, o_red, o_green, o_blue}, 32'd0);

    pix(40, 100, 1'b1);
    rst_pix = 1'b1;
    tick();
    m_mode = 2'd0;
    m_off  = 8'd0;
    check("midreset_outputs", {7'd0, o_de, o_red, o_green, o_blue}, 32'd0);
    check("midreset_mode", {30'd0, o_mode}, 32'd0);
    rst_pix = 1'b0;
    tick();
    check("midreset_de_hold", {31'd0, o_de}, 32'd0);
    tick();
    check("midreset_grad", {7'd0, o_de, o_red, o_green, o_blue}, {8'd1, 24'h6E74B0});

    repeat (3) frame(2'd3, 1'b0);
    show("solid_3_frames", 5, 5, {3{SOLID3}});
    repeat (2) frame(2'd3, 1'b1);
    show("solid_paused", 5, 5, {3{SOLID3}});
    repeat (256) frame(2'd3, 1'b0);
    show("solid_wrapped", 5, 5, {3{SOLID3}});

    // Pixel sampled alongside the frame pulse keeps the old mode and offset.
    pix(40, 100, 1'b1);
    i_mode  = 2'd0;
    i_pause = 1'b0;
    i_frame = 1'b1;
    tick();
    i_frame = 1'b0;
    m_mode  = 2'd0;
    if (SCROLL) m_off = m_off + 8'd1;
    tick();
    check("frame_pixel_old_mode", {7'd0, o_de, o_red, o_green, o_blue}, {8'd1, {3{SOLID3}}});
    tick();
    check("frame_next_new_mode", {7'd0, o_de, o_red, o_green, o_blue},
          {7'd0, model(40, 100, 1'b1, m_mode, m_off)});

    for (int i = 0; i < 162; i++) begin
      int sx, sy;
      logic de, fr;
      logic [1:0] md;
      sx = 0;
      sy = 0;
      de = 1'b0;
      fr = 1'b0;
      md = m_mode;
      if (i < 160) begin
        sx = $urandom_range(0, 799);
        sy = $urandom_range(0, 524);
        de = ($urandom_range(0, 3) != 0);
        fr = ((i % 40) == 20);
        md = 2'($urandom_range(0, 3));
      end
      pix(sx, sy, de);
      i_mode  = md;
      i_frame = fr;
      i_pause = ($urandom_range(0, 3) == 0);
      q.push_back(model(sx, sy, de, m_mode, m_off));
      tick();
      if (fr) begin
        m_mode = md;
        if (SCROLL && !i_pause) m_off = m_off + 8'd1;
      end
      i_frame = 1'b0;
      if (q.size() == 2)
        check("random_stream", {7'd0, o_de, o_red, o_green, o_blue}, {7'd0, q.pop_front()});
    end
    check("random_mode", {30'd0, o_mode}, {30'd0, m_mode});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
